// File: rtl/parking_lane_counter.sv
// parking_lane_counter: per-lane beam-pair FSMs recognise complete entry and
// exit passes. A shared saturating occupancy counter sums every lane's events
// each cycle and produces full/empty plus a sticky error flag.
module parking_lane_counter #(
  parameter  int LANES    = 2,
  parameter  int CAPACITY = 15,
  localparam int CW       = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clr_err,
  output logic [LANES-1:0] entry,
  output logic [LANES-1:0] exit,
  output logic [LANES-1:0] lane_err,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EN1  = 3'd1,
    EN2  = 3'd2,
    EN3  = 3'd3,
    EX1  = 3'd4,
    EX2  = 3'd5,
    EX3  = 3'd6,
    WAIT = 3'd7
  } lane_state_e;

  localparam int TW = CW + 4;
  localparam logic signed [TW-1:0] CAP_S = TW'(CAPACITY);

  lane_state_e      state_q [LANES];
  lane_state_e      state_d [LANES];
  logic [LANES-1:0] entry_q, entry_d;
  logic [LANES-1:0] exit_q, exit_d;
  logic [LANES-1:0] lerr_q, lerr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  // Number of set bits in a lane vector (at most 8 lanes, so 4 bits suffice).
  function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Clamp a signed occupancy candidate into 0..CAPACITY; MSB of result flags a clamp.
  function automatic logic [CW:0] sat_count(input logic signed [TW-1:0] t);
    if (t > CAP_S)
      return {1'b1, CAP_S[CW-1:0]};
    else if (t < 0)
      return {1'b1, {CW{1'b0}}};
    else
      return {1'b0, t[CW-1:0]};
  endfunction

  // Lane FSM next state and one-cycle event pulses.
  always_comb begin
    entry_d = '0;
    exit_d  = '0;
    lerr_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [1:0] code;
      code       = {a[i], b[i]};
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE: begin
          case (code)
            2'b01:   state_d[i] = EN1;
            2'b10:   state_d[i] = EX1;
            2'b11:   begin state_d[i] = WAIT; lerr_d[i] = 1'b1; end
            default: state_d[i] = IDLE;
          endcase
        end
        EN1: begin
          case (code)
            2'b01:   state_d[i] = EN1;
            2'b11:   state_d[i] = EN2;
            2'b00:   state_d[i] = IDLE;
            default: begin state_d[i] = WAIT; lerr_d[i] = 1'b1; end
          endcase
        end
        EN2: begin
          case (code)
            2'b11:   state_d[i] = EN2;
            2'b10:   state_d[i] = EN3;
            2'b01:   state_d[i] = EN1;
            default: begin state_d[i] = IDLE; lerr_d[i] = 1'b1; end
          endcase
        end
        EN3: begin
          case (code)
            2'b10:   state_d[i] = EN3;
            2'b00:   begin state_d[i] = IDLE; entry_d[i] = 1'b1; end
            2'b11:   state_d[i] = EN2;
            default: begin state_d[i] = WAIT; lerr_d[i] = 1'b1; end
          endcase
        end
        EX1: begin
          case (code)
            2'b10:   state_d[i] = EX1;
            2'b11:   state_d[i] = EX2;
            2'b00:   state_d[i] = IDLE;
            default: begin state_d[i] = WAIT; lerr_d[i] = 1'b1; end
          endcase
        end
        EX2: begin
          case (code)
            2'b11:   state_d[i] = EX2;
            2'b01:   state_d[i] = EX3;
            2'b10:   state_d[i] = EX1;
            default: begin state_d[i] = IDLE; lerr_d[i] = 1'b1; end
          endcase
        end
        EX3: begin
          case (code)
            2'b01:   state_d[i] = EX3;
            2'b00:   begin state_d[i] = IDLE; exit_d[i] = 1'b1; end
            2'b11:   state_d[i] = EX2;
            default: begin state_d[i] = WAIT; lerr_d[i] = 1'b1; end
          endcase
        end
        default: begin
          if (code == 2'b00) state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Occupancy update from this edge's events, with saturation and sticky error.
  always_comb begin
    logic signed [TW-1:0] t;
    logic [CW:0]          sat;
    t = $signed({4'b0000, count_q})
      + $signed({{CW{1'b0}}, popcount(entry_d)})
      - $signed({{CW{1'b0}}, popcount(exit_d)});
    sat     = sat_count(t);
    count_d = sat[CW-1:0];
    if (sat[CW] || (|lerr_d))
      err_d = 1'b1;
    else if (clr_err)
      err_d = 1'b0;
    else
      err_d = err_q;
  end

  // State, pulse and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state_q[i] <= IDLE;
      entry_q <= '0;
      exit_q  <= '0;
      lerr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) state_q[i] <= state_d[i];
      entry_q <= entry_d;
      exit_q  <= exit_d;
      lerr_q  <= lerr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign entry    = entry_q;
  assign exit     = exit_q;
  assign lane_err = lerr_q;
  assign count    = count_q;
  assign err      = err_q;
  assign full     = (count_q == CAP_S[CW-1:0]);
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_parking_lane_counter.sv
// Directed bench for parking_lane_counter with LANES=2, CAPACITY=3.
module tb_parking_lane_counter;

  localparam int LANES    = 2;
  localparam int CAPACITY = 3;
  localparam int CW       = $clog2(CAPACITY + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [LANES-1:0] a, b;
  logic             clr_err;
  logic [LANES-1:0] ent, ext, lerr;
  logic [CW-1:0]    count;
  logic             full, empty, err;

  int checks = 0;
  int errors = 0;

  parking_lane_counter #(.LANES(LANES), .CAPACITY(CAPACITY)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .clr_err(clr_err),
    .entry(ent), .exit(ext), .lane_err(lerr),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one code pair, clock it in, then settle past the edge.
  task automatic step(input logic [1:0] av, input logic [1:0] bv);
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  // Run a 4-code pass: lanes in en do an entry, lanes in ex do an exit.
  task automatic pass_seq(input logic [1:0] en, input logic [1:0] ex);
    logic [3:0] ea, eb, xa, xb;
    logic [1:0] av, bv;
    ea = 4'b0110; eb = 4'b0011; xa = 4'b0011; xb = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      av = '0; bv = '0;
      for (int i = 0; i < LANES; i++) begin
        if (en[i]) begin av[i] = ea[k]; bv[i] = eb[k]; end
        if (ex[i]) begin av[i] = xa[k]; bv[i] = xb[k]; end
      end
      step(av, bv);
      if (k < 3) begin
        chk("pass_no_entry", ent, 0);
        chk("pass_no_exit", ext, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; clr_err = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_pulses", {ent, ext, lerr}, 0);
    reset = 1'b0;

    // single entry on lane 0
    step(2'b00, 2'b00);
    pass_seq(2'b01, 2'b00);
    chk("ent0_pulse", ent, 2'b01);
    chk("ent0_count", count, 1);
    chk("ent0_empty", empty, 0);
    step(2'b00, 2'b00);
    chk("ent0_pulse_end", ent, 0);
    chk("ent0_count_hold", count, 1);

    // exit on lane 1 with hesitation: 10,11,11,10,11,01,00
    step(2'b10, 2'b00);
    step(2'b10, 2'b10);
    step(2'b10, 2'b10);
    step(2'b10, 2'b00);
    step(2'b10, 2'b10);
    step(2'b00, 2'b10);
    chk("hes_no_exit", ext, 0);
    chk("hes_count_pre", count, 1);
    step(2'b00, 2'b00);
    chk("hes_exit", ext, 2'b10);
    chk("hes_count", count, 0);
    chk("hes_empty", empty, 1);

    // abort then illegal jump on lane 0
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);
    chk("abort_entry", ent, 0);
    chk("abort_count", count, 0);
    chk("abort_lerr", lerr, 0);
    step(2'b00, 2'b01);
    step(2'b01, 2'b00);
    chk("jump_lerr", lerr, 2'b01);
    chk("jump_err", err, 1);
    step(2'b01, 2'b01);
    chk("wait_holds_11", lerr, 0);
    step(2'b00, 2'b00);
    chk("wait_exit_lerr", lerr, 0);
    chk("err_sticky", err, 1);
    clr_err = 1'b1;
    step(2'b00, 2'b00);
    chk("clr_err", err, 0);
    clr_err = 1'b0;

    // simultaneous events
    pass_seq(2'b11, 2'b00);
    chk("dual_ent_pulse", ent, 2'b11);
    chk("dual_ent_count", count, 2);
    pass_seq(2'b01, 2'b10);
    chk("cancel_ent", ent, 2'b01);
    chk("cancel_ext", ext, 2'b10);
    chk("cancel_count", count, 2);
    pass_seq(2'b11, 2'b00);
    chk("ovf_count", count, 3);
    chk("ovf_full", full, 1);
    chk("ovf_err", err, 1);
    clr_err = 1'b1;
    step(2'b00, 2'b00);
    chk("ovf_clr", err, 0);
    chk("ovf_full_hold", full, 1);
    clr_err = 1'b0;

    // drain to zero, then underflow
    pass_seq(2'b00, 2'b11);
    chk("drain2_count", count, 1);
    pass_seq(2'b00, 2'b01);
    chk("drain1_count", count, 0);
    pass_seq(2'b00, 2'b10);
    chk("udf_exit", ext, 2'b10);
    chk("udf_count", count, 0);
    chk("udf_err", err, 1);
    clr_err = 1'b1;
    step(2'b00, 2'b00);
    chk("udf_clr", err, 0);
    step(2'b01, 2'b01);
    chk("setwin_lerr", lerr, 2'b01);
    chk("setwin_err", err, 1);
    clr_err = 1'b0;
    step(2'b00, 2'b00);
    chk("setwin_sticky", err, 1);
    clr_err = 1'b1;
    step(2'b00, 2'b00);
    chk("setwin_clr", err, 0);
    clr_err = 1'b0;

    // async reset mid-pass
    pass_seq(2'b11, 2'b00);
    chk("pre_rst_count", count, 2);
    step(2'b00, 2'b01);
    step(2'b01, 2'b01);
    #2;
    reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", empty, 1);
    reset = 1'b0;
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    chk("post_rst_no_entry", ent, 0);
    chk("post_rst_no_exit", ext, 0);
    chk("post_rst_count", count, 0);
    pass_seq(2'b01, 2'b00);
    chk("post_rst_entry", ent, 2'b01);
    chk("post_rst_count2", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
